// File: rtl/toast_core.sv
// Toast CPU: single-cycle RV32I core with an internal, byte-addressed instruction ROM
// and a word-wide data-memory port that is read combinationally.

module toast_imem #(
  parameter int IMEM_DEPTH = 1024
) (
  input  logic [31:0] addr,
  output logic [31:0] data
);
  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  // Indexed by byte address; contents are loaded from outside before reset is released.
  logic [31:0] Instruction_data [0:IMEM_DEPTH-1];

  always_comb begin
    data = 32'h0;
    if (addr < 32'(IMEM_DEPTH)) data = Instruction_data[addr[AW-1:0]];
  end
endmodule

module toast_fetch #(
  parameter int IMEM_DEPTH = 1024
) (
  input  logic [31:0] pc,
  output logic [31:0] instr
);
  toast_imem #(.IMEM_DEPTH(IMEM_DEPTH)) RV32I_IMEM (
    .addr (pc),
    .data (instr)
  );
endmodule

module toast_core #(
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_en,
  output logic        mem_rst
);
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] rf [0:31];

  toast_fetch #(.IMEM_DEPTH(IMEM_DEPTH)) IF_inst (
    .pc    (pc),
    .instr (instr)
  );

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  logic [31:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : rf[rs2];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Shared ALU for OP and OP-IMM; instr[30] only alters SUB (register form) and SRA/SRAI.
  logic [31:0]        alu_b, alu_res;
  logic signed [31:0] sra_res;
  logic               alt;

  always_comb begin
    alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    alt     = instr[30] & ((opcode == OPC_OP) | (funct3 == 3'b101));
    sra_res = $signed(rs1_val) >>> alu_b[4:0];
    case (funct3)
      3'b000:  alu_res = alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'b001:  alu_res = rs1_val << alu_b[4:0];
      3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_res = {31'b0, rs1_val < alu_b};
      3'b100:  alu_res = rs1_val ^ alu_b;
      3'b101:  alu_res = alt ? sra_res : (rs1_val >> alu_b[4:0]);
      3'b110:  alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  logic take_branch;
  always_comb begin
    case (funct3)
      3'b000:  take_branch = (rs1_val == rs2_val);
      3'b001:  take_branch = (rs1_val != rs2_val);
      3'b100:  take_branch = $signed(rs1_val) <  $signed(rs2_val);
      3'b101:  take_branch = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  take_branch = rs1_val <  rs2_val;
      3'b111:  take_branch = rs1_val >= rs2_val;
      default: take_branch = 1'b0;
    endcase
  end

  logic [31:0] eff_addr, next_pc, rd_val, store_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        rd_we, store_en;

  always_comb begin
    eff_addr   = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    next_pc    = pc + 32'd4;
    rd_we      = 1'b0;
    rd_val     = alu_res;
    store_en   = 1'b0;
    store_word = mem_rd_data;
    case (eff_addr[1:0])
      2'd0:    ld_byte = mem_rd_data[7:0];
      2'd1:    ld_byte = mem_rd_data[15:8];
      2'd2:    ld_byte = mem_rd_data[23:16];
      default: ld_byte = mem_rd_data[31:24];
    endcase
    ld_half = eff_addr[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    case (opcode)
      OPC_OP, OPC_OPIMM: rd_we = 1'b1;
      OPC_LUI: begin
        rd_we  = 1'b1;
        rd_val = imm_u;
      end
      OPC_AUIPC: begin
        rd_we  = 1'b1;
        rd_val = pc + imm_u;
      end
      OPC_JAL: begin
        rd_we   = 1'b1;
        rd_val  = pc + 32'd4;
        next_pc = pc + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          rd_we   = 1'b1;
          rd_val  = pc + 32'd4;
          next_pc = {eff_addr[31:1], 1'b0};
        end
      end
      OPC_BRANCH: begin
        if (take_branch) next_pc = pc + imm_b;
      end
      OPC_LOAD: begin
        rd_we = 1'b1;
        case (funct3)
          3'b000:  rd_val = {{24{ld_byte[7]}}, ld_byte};
          3'b001:  rd_val = {{16{ld_half[15]}}, ld_half};
          3'b010:  rd_val = mem_rd_data;
          3'b100:  rd_val = {24'h0, ld_byte};
          3'b101:  rd_val = {16'h0, ld_half};
          default: rd_we  = 1'b0;
        endcase
      end
      OPC_STORE: begin
        // Sub-word stores merge into the word currently presented on mem_rd_data.
        store_en = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010);
        case (funct3)
          3'b000: begin
            case (eff_addr[1:0])
              2'd0:    store_word[7:0]   = rs2_val[7:0];
              2'd1:    store_word[15:8]  = rs2_val[7:0];
              2'd2:    store_word[23:16] = rs2_val[7:0];
              default: store_word[31:24] = rs2_val[7:0];
            endcase
          end
          3'b001: begin
            if (eff_addr[1]) store_word[31:16] = rs2_val[15:0];
            else             store_word[15:0]  = rs2_val[15:0];
          end
          default: store_word = rs2_val;
        endcase
      end
      default: ;
    endcase
  end

  // Reset gates the memory port combinationally so no write can slip out while held.
  assign mem_rst     = Reset_n;
  assign mem_wr_en   = store_en & ~Reset_n;
  assign mem_addr    = Reset_n ? 32'h0 : {eff_addr[31:2], 2'b00};
  assign mem_wr_data = Reset_n ? 32'h0 : store_word;

  always_ff @(posedge Clk or posedge Reset_n) begin
    if (Reset_n) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else begin
      pc <= next_pc;
      if (rd_we && (rd != 5'd0)) rf[rd] <= rd_val;
    end
  end
endmodule

// File: tb/tb_toast_core.sv
// Bench for toast_core: directed programs plus random straight-line programs, each cycle
// compared against an instruction-level reference model with its own data memory.

module tb_toast_core;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic [31:0] mem_rd_data, mem_addr, mem_wr_data;
  logic        mem_wr_en, mem_rst;

  toast_core dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .mem_rd_data (mem_rd_data),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_en   (mem_wr_en),
    .mem_rst     (mem_rst)
  );

  always #5 Clk = ~Clk;

  // Data memory seen by the DUT (1 KiB, word addressed)
  logic [31:0] dmem [0:255];
  assign mem_rd_data = dmem[mem_addr[9:2]];
  always @(posedge Clk) if (mem_wr_en) dmem[mem_addr[9:2]] <= mem_wr_data;

  // Reference model state
  logic [31:0] prog  [256];
  logic [31:0] m_x   [32];
  logic [31:0] m_mem [256];
  logic [31:0] m_pc;

  int checks = 0;
  int passes = 0;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] model_fetch(input logic [31:0] a);
    if (a >= 32'd1024 || a[1:0] != 2'b00) return 32'h0;
    return prog[a[9:2]];
  endfunction

  function automatic logic [31:0] model_alu(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return (alt && a[31]) ? ~((~a) >> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Retire one instruction in the model; reports the store the DUT should present this cycle.
  task automatic model_step(output logic we, output logic [31:0] wa, output logic [31:0] wd);
    logic [31:0] ins, a, b, ii, is, ib, ij, nx, res, eff, word, sh;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        wr, cond;
    ins = model_fetch(m_pc);
    rd = ins[11:7]; f3 = ins[14:12];
    a = m_x[ins[19:15]]; b = m_x[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    nx = m_pc + 4; res = 32'h0; wr = 1'b0; we = 1'b0; wa = 32'h0; wd = 32'h0;
    case (ins[6:0])
      7'h33: begin wr = 1'b1; res = model_alu(f3, ins[30], a, b); end
      7'h13: begin wr = 1'b1; res = model_alu(f3, ins[30] && f3 == 3'd5, a, ii); end
      7'h37: begin wr = 1'b1; res = {ins[31:12], 12'h0}; end
      7'h17: begin wr = 1'b1; res = m_pc + {ins[31:12], 12'h0}; end
      7'h6F: begin wr = 1'b1; res = m_pc + 4; nx = m_pc + ij; end
      7'h67: if (f3 == 3'd0) begin wr = 1'b1; res = m_pc + 4; nx = (a + ii) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: cond = a == b;
          3'd1: cond = a != b;
          3'd4: cond = $signed(a) < $signed(b);
          3'd5: cond = !($signed(a) < $signed(b));
          3'd6: cond = a < b;
          3'd7: cond = !(a < b);
          default: cond = 1'b0;
        endcase
        if (cond) nx = m_pc + ib;
      end
      7'h03: begin
        eff = a + ii; word = m_mem[eff[9:2]];
        sh = word >> (8 * eff[1:0]);
        wr = 1'b1;
        case (f3)
          3'd0: res = {{24{sh[7]}}, sh[7:0]};
          3'd1: begin sh = word >> (eff[1] ? 16 : 0); res = {{16{sh[15]}}, sh[15:0]}; end
          3'd2: res = word;
          3'd4: res = {24'h0, sh[7:0]};
          3'd5: begin sh = word >> (eff[1] ? 16 : 0); res = {16'h0, sh[15:0]}; end
          default: wr = 1'b0;
        endcase
      end
      7'h23: begin
        eff = a + is; word = m_mem[eff[9:2]];
        we = (f3 <= 3'd2); wa = {eff[31:2], 2'b00};
        case (f3)
          3'd0: wd = (word & ~(32'hFF << (8 * eff[1:0]))) | ((b & 32'hFF) << (8 * eff[1:0]));
          3'd1: wd = (word & ~(32'hFFFF << (eff[1] ? 16 : 0))) | ((b & 32'hFFFF) << (eff[1] ? 16 : 0));
          default: wd = b;
        endcase
        if (we) m_mem[eff[9:2]] = wd;
      end
      default: ;
    endcase
    if (wr && rd != 5'd0) m_x[rd] = res;
    m_pc = nx;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 256; i++) begin prog[i] = 32'h0; dmem[i] = 32'h0; m_mem[i] = 32'h0; end
  endtask

  // Assert reset, load the ROM image, hold 100 ns, release on a falling edge.
  task automatic start_prog();
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 1024; i++)
      dut.IF_inst.RV32I_IMEM.Instruction_data[i] = (i % 4 == 0) ? prog[i / 4] : 32'h0;
    m_pc = 32'h0;
    for (int r = 0; r < 32; r++) m_x[r] = 32'h0;
    #100;
    @(negedge Clk);
    Reset_n = 1'b0;
  endtask

  // One cycle: check the memory port before the edge, architectural state after it.
  task automatic step(input string tag);
    logic        we;
    logic [31:0] wa, wd;
    int          bad;
    #1;
    model_step(we, wa, wd);
    checks++;
    if (mem_wr_en !== we || (we && (mem_addr !== wa || mem_wr_data !== wd)))
      $display("FAIL %s_mem got en=%b addr=%h data=%h want en=%b addr=%h data=%h",
               tag, mem_wr_en, mem_addr, mem_wr_data, we, wa, wd);
    else passes++;
    @(posedge Clk);
    #1;
    bad = -1;
    for (int r = 0; r < 32; r++) if (bad < 0 && dut.rf[r] !== m_x[r]) bad = r;
    checks++;
    if (dut.pc !== m_pc) $display("FAIL %s_pc got %h want %h", tag, dut.pc, m_pc);
    else if (bad >= 0) $display("FAIL %s_x%0d got %h want %h", tag, bad, dut.rf[bad], m_x[bad]);
    else passes++;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    int nz;
    #20;
    nz = 0;
    for (int r = 0; r < 32; r++) if (dut.rf[r] !== 32'h0) nz++;
    checks++;
    if (dut.pc !== 32'h0 || nz != 0) $display("FAIL reset_state got pc=%h nonzero_regs=%0d want pc=0 0", dut.pc, nz);
    else passes++;
    checks++;
    if (mem_wr_en !== 1'b0 || mem_rst !== 1'b1 || mem_addr !== 32'h0 || mem_wr_data !== 32'h0)
      $display("FAIL reset_port got en=%b rst=%b addr=%h data=%h want 0 1 0 0", mem_wr_en, mem_rst, mem_addr, mem_wr_data);
    else passes++;
  endtask

  task automatic test_basic_add();
    clear_all();
    prog[1] = enc_i(12'd1, 5'd0, 3'd0, 5'd4, 7'h13);
    prog[2] = enc_i(12'd2, 5'd0, 3'd0, 5'd5, 7'h13);
    prog[3] = enc_r(7'h00, 5'd5, 5'd4, 3'd0, 5'd6);
    start_prog();
    for (int c = 0; c < 4; c++) step("add");
    checks++;
    if (dut.rf[4] !== 32'd1 || dut.rf[5] !== 32'd2 || dut.rf[6] !== 32'd3)
      $display("FAIL add_result got x4=%h x5=%h x6=%h want 1 2 3", dut.rf[4], dut.rf[5], dut.rf[6]);
    else passes++;
  endtask

  task automatic test_x0_nop();
    clear_all();
    prog[0] = enc_i(12'd3, 5'd0, 3'd0, 5'd7, 7'h13);
    prog[1] = enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13);
    prog[2] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7);
    start_prog();
    for (int c = 0; c < 5; c++) step("x0");
    checks++;
    if (dut.rf[0] !== 32'h0 || dut.rf[7] !== 32'h0 || dut.pc !== 32'd20)
      $display("FAIL x0_nop got x0=%h x7=%h pc=%h want 0 0 14", dut.rf[0], dut.rf[7], dut.pc);
    else passes++;
  endtask

  task automatic test_shifts();
    clear_all();
    prog[0] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13);
    prog[1] = enc_i(12'h404, 5'd1, 3'd5, 5'd2, 7'h13);
    prog[2] = enc_i(12'h004, 5'd1, 3'd5, 5'd3, 7'h13);
    prog[3] = enc_i(12'hFFF, 5'd0, 3'd3, 5'd4, 7'h13);
    prog[4] = enc_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd5);
    start_prog();
    for (int c = 0; c < 5; c++) step("shift");
    checks++;
    if (dut.rf[2] !== 32'hFFFF_FFFF || dut.rf[3] !== 32'h0FFF_FFFF)
      $display("FAIL shift_res got srai=%h srli=%h want ffffffff 0fffffff", dut.rf[2], dut.rf[3]);
    else passes++;
    checks++;
    if (dut.rf[4] !== 32'd1 || dut.rf[5] !== 32'd1)
      $display("FAIL slt_res got sltiu=%h slt=%h want 1 1", dut.rf[4], dut.rf[5]);
    else passes++;
  endtask

  task automatic test_store_load();
    clear_all();
    dmem[64] = 32'h1122_3344; m_mem[64] = 32'h1122_3344;
    prog[0] = enc_i(12'h100, 5'd0, 3'd0, 5'd1, 7'h13);
    prog[1] = enc_i(12'h0A5, 5'd0, 3'd0, 5'd2, 7'h13);
    prog[2] = enc_s(12'd3, 5'd2, 5'd1, 3'd0);
    prog[3] = enc_i(12'd3, 5'd1, 3'd0, 5'd3, 7'h03);
    start_prog();
    step("sl"); step("sl");
    #1;
    checks++;
    if (mem_addr !== 32'h100 || mem_wr_en !== 1'b1 || mem_wr_data !== 32'hA522_3344)
      $display("FAIL sb_port got addr=%h en=%b data=%h want 100 1 a5223344", mem_addr, mem_wr_en, mem_wr_data);
    else passes++;
    step("sl");
    dmem[64] = 32'hA500_0000; m_mem[64] = 32'hA500_0000;
    step("sl");
    checks++;
    if (dut.rf[3] !== 32'hFFFF_FFA5) $display("FAIL lb_sext got %h want ffffffa5", dut.rf[3]);
    else passes++;
  endtask

  task automatic test_branch_jump();
    clear_all();
    prog[4] = enc_b(13'd8, 5'd1, 5'd1, 3'd0);
    prog[5] = enc_i(12'd7, 5'd0, 3'd0, 5'd9, 7'h13);
    prog[6] = enc_j(21'h1FFFF8, 5'd1);
    start_prog();
    for (int c = 0; c < 5; c++) step("beq");
    checks++;
    if (dut.pc !== 32'd24 || dut.rf[9] !== 32'h0) $display("FAIL beq_taken got pc=%h x9=%h want 18 0", dut.pc, dut.rf[9]);
    else passes++;
    step("jal");
    checks++;
    if (dut.pc !== 32'd16 || dut.rf[1] !== 32'd28) $display("FAIL jal_back got pc=%h x1=%h want 10 1c", dut.pc, dut.rf[1]);
    else passes++;

    clear_all();
    prog[6]  = enc_j(21'd8, 5'd1);
    prog[8]  = enc_i(12'd1, 5'd1, 3'd0, 5'd0, 7'h67);
    prog[7]  = enc_i(12'd12, 5'd1, 3'd0, 5'd1, 7'h67);
    prog[10] = enc_b(13'h1FD8, 5'd0, 5'd1, 3'd1);
    start_prog();
    for (int c = 0; c < 8; c++) step("jalr");
    checks++;
    if (dut.pc !== 32'd28) $display("FAIL jalr_lsb got pc=%h want 1c", dut.pc);
    else passes++;
    step("jalr");
    checks++;
    if (dut.pc !== 32'd40 || dut.rf[1] !== 32'd32) $display("FAIL jalr_same got pc=%h x1=%h want 28 20", dut.pc, dut.rf[1]);
    else passes++;
    step("bne");
    checks++;
    if (dut.pc !== 32'd0) $display("FAIL bne_back got pc=%h want 0", dut.pc);
    else passes++;
  endtask

  task automatic test_fetch_beyond();
    clear_all();
    prog[0]   = enc_j(21'd1020, 5'd0);
    prog[255] = enc_i(12'd9, 5'd0, 3'd0, 5'd5, 7'h13);
    start_prog();
    for (int c = 0; c < 4; c++) step("beyond");
    checks++;
    if (dut.pc !== 32'd1032 || dut.rf[5] !== 32'd9) $display("FAIL beyond got pc=%h x5=%h want 408 9", dut.pc, dut.rf[5]);
    else passes++;
  endtask

  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      clear_all();
      for (int i = 0; i < 256; i++) begin dmem[i] = $urandom; m_mem[i] = dmem[i]; end
      for (int k = 0; k < 60; k++) begin
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3, mf;
        logic [11:0] imm;
        logic [31:0] u, w;
        rd = 5'($urandom_range(0, 15)); r1 = 5'($urandom_range(0, 15)); r2 = 5'($urandom_range(0, 15));
        f3 = 3'($urandom_range(0, 7)); imm = 12'($urandom); u = $urandom;
        case ($urandom_range(0, 9))
          0, 1: w = enc_r(((f3 == 3'd0 || f3 == 3'd5) && u[0]) ? 7'h20 : 7'h00, r2, r1, f3, rd);
          2, 3: begin
            if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
            else if (f3 == 3'd5) imm = {1'b0, imm[10], 5'h00, imm[4:0]};
            w = enc_i(imm, r1, f3, rd, 7'h13);
          end
          4: w = {u[31:12], rd, u[0] ? 7'h37 : 7'h17};
          5: begin
            mf = (f3 == 3'd3) ? 3'd1 : (f3 == 3'd6) ? 3'd2 : (f3 == 3'd7) ? 3'd4 : f3;
            w = enc_i(12'($urandom_range(0, 1023)), 5'd0, mf, rd, 7'h03);
          end
          6: w = enc_s(12'($urandom_range(0, 1023)), r2, 5'd0, 3'($urandom_range(0, 2)));
          7: begin
            mf = (f3 == 3'd2) ? 3'd0 : (f3 == 3'd3) ? 3'd1 : f3;
            w = enc_b(13'd8, r2, r1, mf);
          end
          8: w = enc_j(21'd8, rd);
          default: w = (u[1:0] == 2'd0) ? 32'h0000_0073 : (u[1:0] == 2'd1) ? 32'h0000_000F : 32'h0;
        endcase
        prog[k] = w;
      end
      start_prog();
      for (int c = 0; c < 70; c++) step("rand");
    end
  endtask

  task automatic test_reset_mid();
    int nz;
    clear_all();
    prog[0] = enc_s(12'h040, 5'd2, 5'd0, 3'd2);
    prog[1] = enc_i(12'h055, 5'd0, 3'd0, 5'd2, 7'h13);
    prog[2] = enc_i(12'd1, 5'd2, 3'd0, 5'd3, 7'h13);
    prog[3] = enc_s(12'h044, 5'd3, 5'd0, 3'd2);
    prog[4] = enc_j(21'h1FFFFC, 5'd0);
    start_prog();
    for (int c = 0; c < 6; c++) step("mid");
    #2;
    Reset_n = 1'b1;
    #1;
    nz = 0;
    for (int r = 0; r < 32; r++) if (dut.rf[r] !== 32'h0) nz++;
    checks++;
    if (dut.pc !== 32'h0 || nz != 0) $display("FAIL midreset_state got pc=%h nonzero_regs=%0d want 0 0", dut.pc, nz);
    else passes++;
    checks++;
    if (mem_wr_en !== 1'b0 || mem_rst !== 1'b1) $display("FAIL midreset_port got en=%b rst=%b want 0 1", mem_wr_en, mem_rst);
    else passes++;
    m_pc = 32'h0;
    for (int r = 0; r < 32; r++) m_x[r] = 32'h0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    for (int c = 0; c < 6; c++) step("rerun");
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_x0_nop();
    test_shifts();
    test_store_load();
    test_branch_jump();
    test_fetch_beyond();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
